jtdsp16_extarb: RTL
===================

# jtdsp16_extarb

External bus arbiter for the DSP16 core. Shares one external memory port between the program fetch unit and the data/parallel-I/O unit. Issues bus cycles with fair round-robin arbitration and latches the read data. Drives the `ext_rq`/`ext_ok` pair that freezes the core's divided clock enable while any access is outstanding.

## Interface
- `AW`, 16, address width of both requesters and the bus
- `DW`, 16, data width

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `pr_rq`  in  1  program fetch request, level
- `pr_addr`  in  AW  program address
- `pr_dout`  out  DW  fetched word, valid while `pr_ok`
- `pr_ok`  out  1  program access served, level
- `dt_rq`  in  1  data request, level
- `dt_we`  in  1  1 = write, 0 = read
- `dt_addr`  in  AW  data address
- `dt_din`  in  DW  write data
- `dt_dout`  out  DW  read word, valid while `dt_ok`
- `dt_ok`  out  1  data access served, level
- `bus_cs`  out  1  bus cycle active
- `bus_we`  out  1  bus write strobe
- `bus_addr`  out  AW  bus address
- `bus_din`  out  DW  write data to memory
- `bus_dout`  in  DW  read data from memory
- `bus_ok`  in  1  memory acknowledge; one-cycle pulse
- `ext_rq`  out  1  any request pending, to clock-enable divider
- `ext_ok`  out  1  all pending requests served, to clock-enable divider

## Operation
- Per-requester state: `pend` (needs service) and `done` (served). `pr_ok`=`pr_done`, `dt_ok`=`dt_done`.
- A requester becomes pending when its `rq` rises, and also when its address changes while `rq` is high (data: address or `dt_we` change). That change clears `done`.
- Dropping `rq` clears `done`. If that requester's bus cycle is in flight, the cycle completes on the bus, its data is discarded, and `done` is not set.
- FSM states: IDLE, BUS, GAP.
  - IDLE: if any `pend` is set, choose a winner, register `bus_addr`/`bus_we`/`bus_din`, assert `bus_cs`, and go to BUS.
  - BUS: hold all bus outputs. On `bus_ok`, deassert `bus_cs`. For reads, latch `bus_dout` into the winner's dout. Set the winner's `done`, clear its `pend`, and go to GAP.
  - GAP: one turnaround cycle, then IDLE.
- Arbitration: round-robin via a `last` bit. If both requesters are pending, the one not served last wins. If only one is pending, it wins. Reset value of `last` is data, so program wins the first tie.
- A write sets `dt_done`; `dt_dout` is unchanged.
- `ext_rq` = `pr_rq | dt_rq`, combinational.
- `ext_ok` = `(!pr_rq | pr_done) & (!dt_rq | dt_done)`, combinational.

## Timing
- Reset values: `bus_cs`=0, `bus_we`=0, `bus_addr`=0, `bus_din`=0, `pr_dout`=0, `dt_dout`=0, `pr_ok`=0, `dt_ok`=0, FSM=IDLE, `pend`=0, `last`=data.
- With combinational inputs, `ext_rq`=0 and `ext_ok`=1 while `pr_rq`=`dt_rq`=0.
- `rq` rises in cycle n → `pend` is set at edge n+1. The arbiter is in IDLE during n+1, so `bus_cs` is registered high at edge n+2.
- `bus_ok` is sampled in cycle m → `bus_cs` goes low and `ok` goes high at edge m+1.
- Minimum request-to-ok latency: 4 cycles with zero-wait memory.
- Back-to-back transactions are separated by exactly one GAP cycle, so `bus_cs` is low for at least 2 cycles between them.
- `bus_ok` outside BUS is ignored.
- Address change and `bus_ok` in the same cycle: the in-flight result is delivered, but the new change re-sets `pend` and clears `done` in the same cycle (restart wins).
- `rst` asserted mid-BUS: `bus_cs` drops at the next edge and all state clears. Any late `bus_ok` is ignored.

## Structure
- Package `jtdsp16_pkg`: FSM state encoding `ST_IDLE`, `ST_BUS`, `ST_GAP`, and the requester index constants `REQ_PR`=0, `REQ_DT`=1.
- One natural sub-module: `jtdsp16_extarb_port`, instantiated twice. It holds a requester's `pend`/`done` bits, the previous-address register for change detection, and the dout latch. The top holds the FSM, arbitration and bus registers.

## Test plan
- Single program read:
  - Stimulus: `pr_addr`=0x0123, `pr_rq` rises; memory returns 0xBEEF with `bus_ok` 1 cycle after `bus_cs`.
  - Required: `pr_ok` and `ext_ok` go high 4 cycles after `rq`; `pr_dout`=0xBEEF; `ext_rq` stays 1 until `rq` drops.
- Simultaneous requests:
  - Stimulus: `pr_rq` and `dt_rq` rise in the same cycle after reset.
  - Required: program is served first, then data after the GAP cycle; `ext_ok`=1 only after `dt_ok`.
- Data write:
  - Stimulus: `dt_we`=1, `dt_addr`=0x0040, `dt_din`=0x5A5A.
  - Required: `bus_we`=1 and `bus_din`=0x5A5A for the whole BUS state; `dt_ok`=1; `dt_dout` unchanged.
- Sequential fetch:
  - Stimulus: `pr_rq` held high while `pr_addr` steps 0x10 → 0x11 after `pr_ok`.
  - Required: `pr_ok` drops on the address change; a new bus cycle starts at 0x11; `ext_ok`=0 until it completes.
- Abort:
  - Stimulus: `dt_rq` drops during BUS.
  - Required: the bus cycle completes, `dt_ok` stays 0, and `dt_dout` is unchanged.
- Reset mid-transaction:
  - Stimulus: `rst` pulsed during BUS.
  - Required: all outputs reach their reset values at the next edge; a subsequent `bus_ok` has no effect.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared encodings for the DSP16 external bus arbiter: FSM states and
// requester indices used by the round-robin "last served" bit.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } st_t;

  localparam logic REQ_PR = 1'b0;
  localparam logic REQ_DT = 1'b1;

endpackage

// File: rtl/jtdsp16_extarb_port.sv
// One requester of the external arbiter: change detection on rq/key,
// pend/done bookkeeping and the read-data latch.
module jtdsp16_extarb_port
  import jtdsp16_pkg::*;
#(
  parameter int KW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq,
  input  logic [KW-1:0] key,
  input  logic          busy,
  input  logic          serve,
  input  logic          rd,
  input  logic [DW-1:0] rdata,
  output logic          pend,
  output logic          done,
  output logic [DW-1:0] dout
);

  logic          prev_rq;
  logic [KW-1:0] prev_key;
  logic          stale;
  logic          start;

  // A new access starts on an rq rise or on a key change with rq held high.
  assign start = rq & (!prev_rq | (key != prev_key));

  // stale marks a bus cycle in flight whose request was restarted before
  // bus_ok: its result belongs to the old key, so it is re-issued instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rq  <= 1'b0;
      prev_key <= '0;
      pend     <= 1'b0;
      done     <= 1'b0;
      stale    <= 1'b0;
      dout     <= '0;
    end else begin
      prev_rq  <= rq;
      prev_key <= key;
      if (serve && rq && rd && !stale) dout <= rdata;
      if (!rq) begin
        pend  <= 1'b0;
        done  <= 1'b0;
        stale <= 1'b0;
      end else if (start) begin
        pend  <= 1'b1;
        done  <= 1'b0;
        stale <= busy & !serve;
      end else if (serve) begin
        pend  <= stale;
        done  <= !stale;
        stale <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_extarb.sv
// External bus arbiter for the DSP16: round-robin between program fetch
// and data port, one bus cycle at a time, with a turnaround GAP cycle.
module jtdsp16_extarb
  import jtdsp16_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pr_rq,
  input  logic [AW-1:0] pr_addr,
  output logic [DW-1:0] pr_dout,
  output logic          pr_ok,
  input  logic          dt_rq,
  input  logic          dt_we,
  input  logic [AW-1:0] dt_addr,
  input  logic [DW-1:0] dt_din,
  output logic [DW-1:0] dt_dout,
  output logic          dt_ok,
  output logic          bus_cs,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_din,
  input  logic [DW-1:0] bus_dout,
  input  logic          bus_ok,
  output logic          ext_rq,
  output logic          ext_ok
);

  // Handshake: rq is a level held until ok is seen; dropping rq abandons
  // the access. bus_cs stays high until the single-cycle bus_ok pulse.
  st_t  st;
  logic win;
  logic last;
  logic pick;
  logic pr_pend, dt_pend;
  logic pr_busy, dt_busy;
  logic pr_serve, dt_serve;

  assign pr_busy  = (st == ST_BUS) && (win == REQ_PR);
  assign dt_busy  = (st == ST_BUS) && (win == REQ_DT);
  assign pr_serve = pr_busy & bus_ok;
  assign dt_serve = dt_busy & bus_ok;

  jtdsp16_extarb_port #(.KW(AW), .DW(DW)) u_pr (
    .clk   (clk),
    .rst   (rst),
    .rq    (pr_rq),
    .key   (pr_addr),
    .busy  (pr_busy),
    .serve (pr_serve),
    .rd    (1'b1),
    .rdata (bus_dout),
    .pend  (pr_pend),
    .done  (pr_ok),
    .dout  (pr_dout)
  );

  jtdsp16_extarb_port #(.KW(AW + 1), .DW(DW)) u_dt (
    .clk   (clk),
    .rst   (rst),
    .rq    (dt_rq),
    .key   ({dt_we, dt_addr}),
    .busy  (dt_busy),
    .serve (dt_serve),
    .rd    (!bus_we),
    .rdata (bus_dout),
    .pend  (dt_pend),
    .done  (dt_ok),
    .dout  (dt_dout)
  );

  // On a tie the requester not served last wins.
  always_comb begin
    pick = REQ_PR;
    if (pr_pend && dt_pend) pick = ~last;
    else if (dt_pend)       pick = REQ_DT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      win      <= REQ_PR;
      last     <= REQ_DT;
      bus_cs   <= 1'b0;
      bus_we   <= 1'b0;
      bus_addr <= '0;
      bus_din  <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (pr_pend || dt_pend) begin
            win    <= pick;
            bus_cs <= 1'b1;
            st     <= ST_BUS;
            if (pick == REQ_DT) begin
              bus_addr <= dt_addr;
              bus_we   <= dt_we;
              bus_din  <= dt_din;
            end else begin
              bus_addr <= pr_addr;
              bus_we   <= 1'b0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ok) begin
            bus_cs <= 1'b0;
            bus_we <= 1'b0;
            last   <= win;
            st     <= ST_GAP;
          end
        end
        ST_GAP:  st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign ext_rq = pr_rq | dt_rq;
  assign ext_ok = (!pr_rq | pr_ok) & (!dt_rq | dt_ok);

endmodule
